// File: rtl/alu_muldiv_seq.sv
// ---------------------------------------------------------------------------
// alu_muldiv_seq
//
// Iterative radix-2 multiply / divide engine that sits beside the ALU in EX.
// It replaces the single-cycle `*`, `/` and `%` paths. Every operation takes a
// fixed number of cycles and has no early-out.
//
//   MUL : unsigned shift-add.
//         {result2, result1} = a * b
//   DIV : unsigned restoring division.
//         result1 = a / b, result2 = a % b
//         Divide by zero yields quotient = all ones and remainder = a.
//
// Timing, for a start accepted at edge k:
//   - busy is high after edges k .. k+WIDTH-1.
//   - At edge k+WIDTH, done pulses for one cycle and the results update.
//   - The next start can be accepted one cycle after done.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   synchronous active-low reset
//   start    in   request; sampled only in IDLE
//   cancel   in   abort the operation in flight (pipeline flush)
//   op       in   [3:0] operation code, sampled with start
//   a        in   [WIDTH-1:0] multiplicand / dividend, sampled with start
//   b        in   [WIDTH-1:0] multiplier / divisor, sampled with start
//   busy     out  high while iterating
//   done     out  one-cycle pulse when result1/result2 update
//   result1  out  [WIDTH-1:0] product low word / quotient
//   result2  out  [WIDTH-1:0] product high word / remainder
// ---------------------------------------------------------------------------
module alu_muldiv_seq #(
    parameter int         WIDTH  = 32,
    parameter logic [3:0] OP_MUL = 4'b0011,
    parameter logic [3:0] OP_DIV = 4'b0100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cancel,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result1,
    output logic [WIDTH-1:0] result2
);

    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;

    // MUL: r_opa is the multiplicand.
    // DIV: r_opa starts as the dividend; quotient bits shift in at its LSB
    //      while dividend bits leave at its MSB.
    logic [WIDTH-1:0]   r_opa;

    // MUL: r_opb is the multiplier and shifts right each step.
    // DIV: r_opb is the divisor and stays constant.
    logic [WIDTH-1:0]   r_opb;

    // MUL: r_acc holds the full 2*WIDTH product.
    // DIV: the low WIDTH bits hold the partial remainder.
    logic [2*WIDTH-1:0] r_acc;

    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_res1;
    logic [WIDTH-1:0]   r_res2;

    // ---------------- multiply step ----------------
    // The upper-half add keeps its carry (WIDTH+1 bits). The carry becomes the
    // MSB of the product after the right shift.
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;

    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + (r_opb[0] ? {1'b0, r_opa} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // ---------------- divide step ----------------
    // The shifted remainder can reach WIDTH+1 bits, so the compare is done at
    // WIDTH+1 bits. When the subtract happens, the true difference is below the
    // divisor and therefore fits in WIDTH bits. The low-word subtraction is
    // exact in that case.
    // With a zero divisor, every step subtracts nothing. The quotient fills
    // with ones and the dividend bits pass straight into the remainder.
    logic [WIDTH:0]     w_rem_sh;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_rem_diff;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quo_next;

    assign w_rem_sh   = {r_acc[WIDTH-1:0], r_opa[WIDTH-1]};
    assign w_div_ge   = (w_rem_sh >= {1'b0, r_opb});
    assign w_rem_diff = w_rem_sh[WIDTH-1:0] - r_opb;
    assign w_rem_next = w_div_ge ? w_rem_diff : w_rem_sh[WIDTH-1:0];
    assign w_quo_next = {r_opa[WIDTH-2:0], w_div_ge};

    logic w_op_valid;
    assign w_op_valid = (op == OP_MUL) || (op == OP_DIV);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_opa   <= '0;
            r_opb   <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_res1  <= '0;
            r_res2  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // cancel in the same cycle as start suppresses the request
                    if (start && !cancel && w_op_valid) begin
                        r_opa   <= a;
                        r_opb   <= b;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= (op == OP_MUL) ? S_MUL : S_DIV;
                    end
                end

                S_MUL, S_DIV: begin
                    if (cancel) begin
                        // Flush: partial work is dropped and results are kept.
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        if (r_state == S_MUL) begin
                            r_acc <= w_mul_next;
                            r_opb <= r_opb >> 1;
                        end else begin
                            r_acc[WIDTH-1:0] <= w_rem_next;
                            r_opa            <= w_quo_next;
                        end
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_LAST) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            if (r_state == S_MUL) begin
                                r_res1 <= w_mul_next[WIDTH-1:0];
                                r_res2 <= w_mul_next[2*WIDTH-1:WIDTH];
                            end else begin
                                r_res1 <= w_quo_next;
                                r_res2 <= w_rem_next;
                            end
                        end
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign result1 = r_res1;
    assign result2 = r_res2;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_muldiv_seq
//
// Testbench for alu_muldiv_seq.
//   - A table of fixed vectors.
//   - Hand-written multi-cycle sequences: cancel, ignored starts, start in
//     DONE, cancel together with start, and reset mid-operation.
//   - Random operations checked against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_alu_muldiv_seq;

    localparam int         W      = 32;
    localparam logic [3:0] OP_MUL = 4'b0011;
    localparam logic [3:0] OP_DIV = 4'b0100;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         cancel;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result1;
    logic [W-1:0] result2;

    int checks = 0;
    int errors = 0;

    alu_muldiv_seq #(
        .WIDTH (W),
        .OP_MUL(OP_MUL),
        .OP_DIV(OP_DIV)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .cancel (cancel),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result1(result1),
        .result2(result2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] e1;
        logic [W-1:0] e2;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference model, returned as {result2, result1}.
    function automatic logic [63:0] ref_model(input logic [3:0] o,
                                              input logic [W-1:0] x,
                                              input logic [W-1:0] y);
        logic [63:0] r;
        if (o == OP_MUL) begin
            r = 64'(x) * 64'(y);
        end else if (y == 0) begin
            r = {x, 32'hFFFF_FFFF};
        end else begin
            r = {32'(x % y), 32'(x / y)};
        end
        return r;
    endfunction

    // Called at a negedge while the DUT is idle.
    //   restart_at >= 0 : re-assert start with other operands mid-flight.
    //   sid             : assert start during the DONE cycle.
    // Returns at a negedge with the DUT back in IDLE.
    task automatic do_op(input logic [3:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic [W-1:0] e1, input logic [W-1:0] e2,
                         input int restart_at, input bit sid, input string nm);
        int cyc;
        bit seen;
        start = 1'b1; op = o; a = xa; b = xb;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        cyc = 0; seen = 1'b0;
        while (cyc < 40) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            chk({nm, ".busy"}, 64'(busy), 64'd1);
            if (cyc == restart_at) begin
                start = 1'b1; op = OP_MUL; a = $urandom; b = $urandom;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk({nm, ".done_seen"}, 64'(seen), 64'd1);
        chk({nm, ".latency"}, 64'(cyc), 64'(W));
        chk({nm, ".busy_at_done"}, 64'(busy), 64'd0);
        chk({nm, ".result1"}, 64'(result1), 64'(e1));
        chk({nm, ".result2"}, 64'(result2), 64'(e2));
        if (sid) begin
            start = 1'b1; op = OP_DIV; a = 32'd99; b = 32'd3;
        end
        @(negedge clk);
        start = 1'b0;
        chk({nm, ".done_fall"}, 64'(done), 64'd0);
        chk({nm, ".idle_busy"}, 64'(busy), 64'd0);
    endtask

    // Watch n cycles and check that done never pulses.
    task automatic no_done(input int n, input string nm);
        bit saw;
        saw = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) saw = 1'b1;
        end
        chk({nm, ".no_done"}, 64'(saw), 64'd0);
    endtask

    initial begin
        logic [63:0] m;
        logic [3:0]  ro;
        logic [W-1:0] ra, rb;

        tbl[0]  = '{OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE};
        tbl[1]  = '{OP_DIV, 32'd100,       32'd7,         32'd14,        32'd2};
        tbl[2]  = '{OP_DIV, 32'd7,         32'd100,       32'd0,         32'd7};
        tbl[3]  = '{OP_DIV, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 32'h1234_5678};
        tbl[4]  = '{OP_MUL, 32'd0,         32'h0001_2345, 32'd0,         32'd0};
        tbl[5]  = '{OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'd0,         32'd1};
        tbl[6]  = '{OP_MUL, 32'h8000_0000, 32'd2,         32'd0,         32'd1};
        tbl[7]  = '{OP_MUL, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE, 32'd1};
        tbl[8]  = '{OP_DIV, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0};
        tbl[9]  = '{OP_DIV, 32'd0,         32'd5,         32'd0,         32'd0};
        tbl[10] = '{OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
        tbl[11] = '{OP_DIV, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         32'd0};
        tbl[12] = '{OP_MUL, 32'd3,         32'd5,         32'd15,        32'd0};

        rst_n = 1'b0; start = 1'b0; cancel = 1'b0; op = 4'd0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("reset.busy", 64'(busy), 64'd0);
        chk("reset.done", 64'(done), 64'd0);
        chk("reset.result1", 64'(result1), 64'd0);
        chk("reset.result2", 64'(result2), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table vectors, issued back-to-back.
        for (int i = 0; i < 13; i++) begin
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].e1, tbl[i].e2, -1, 1'b0,
                  $sformatf("vec%0d", i));
        end

        // Cancel MUL 3*5 at iteration 10; the prior DIV result must survive.
        do_op(OP_DIV, 32'd100, 32'd7, 32'd14, 32'd2, -1, 1'b0, "pre_cancel");
        start = 1'b1; op = OP_MUL; a = 32'd3; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel.busy", 64'(busy), 64'd0);
        chk("cancel.done", 64'(done), 64'd0);
        chk("cancel.result1", 64'(result1), 64'hE);
        chk("cancel.result2", 64'(result2), 64'h2);
        no_done(40, "cancel");
        chk("cancel.hold1", 64'(result1), 64'hE);
        do_op(OP_MUL, 32'd3, 32'd5, 32'd15, 32'd0, -1, 1'b0, "after_cancel");

        // Start re-asserted mid-flight; the original operands must win.
        do_op(OP_MUL, 32'd1000, 32'd1000, 32'd1000000, 32'd0, 5, 1'b0, "restart_busy");

        // Start during the DONE cycle is ignored.
        do_op(OP_DIV, 32'd50, 32'd6, 32'd8, 32'd2, -1, 1'b1, "start_in_done");
        no_done(40, "start_in_done");
        chk("start_in_done.hold", 64'(result1), 64'd8);

        // Unsupported op is ignored.
        start = 1'b1; op = 4'b0101; a = 32'd9; b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        chk("bad_op.busy", 64'(busy), 64'd0);
        no_done(40, "bad_op");
        chk("bad_op.hold2", 64'(result2), 64'd2);

        // Cancel together with start in IDLE: start is dropped.
        start = 1'b1; cancel = 1'b1; op = OP_MUL; a = 32'd4; b = 32'd4;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        chk("cancel_start.busy", 64'(busy), 64'd0);
        no_done(40, "cancel_start");

        // Random operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            ro = ($urandom_range(0, 1) == 0) ? OP_MUL : OP_DIV;
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1, 2:    rb = W'($urandom_range(1, 300));
                default: rb = $urandom;
            endcase
            m = ref_model(ro, ra, rb);
            do_op(ro, ra, rb, m[31:0], m[63:32], -1, 1'b0, $sformatf("rnd%0d", i));
        end

        // Reset while a MUL is in flight: all work is discarded.
        start = 1'b1; op = OP_MUL; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mid.busy", 64'(busy), 64'd0);
        chk("rst_mid.done", 64'(done), 64'd0);
        chk("rst_mid.result1", 64'(result1), 64'd0);
        chk("rst_mid.result2", 64'(result2), 64'd0);
        rst_n = 1'b1;
        no_done(40, "rst_mid");
        chk("rst_mid.busy_after", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
